// File: rtl/wb_pipe_master.sv
// WISHBONE B4 pipelined burst master for the NIC transmit queue.
// Define WB_MASTER_TIMEOUT_EN to add an ACK watchdog that aborts like ERR_I.
module wb_pipe_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BURST_W     = 7,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 255,
  localparam int SEL_W      = DATA_W / 8,
  localparam int OUT_W      = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              we_i,
  input  logic [BURST_W-1:0] len_i,
  output logic              next_o,
  output logic              done_o,
  output logic              retry_o,
  output logic              error_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              gnt_i,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic              ACK_I,
  input  logic              RTY_I,
  input  logic              ERR_I,
  input  logic              STALL_I,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic [SEL_W-1:0]  SEL_O,
  output logic [2:0]        CTI_O
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_RTY   = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [BURST_W-1:0] sent_q, sent_d;
  logic [BURST_W-1:0] acked_q, acked_d;
  logic [OUT_W-1:0]   outst_q, outst_d;

  logic               active;
  logic               accept;
  logic               last_acc;
  logic               last_ack;
  logic               abort_err;
  logic               abort_rty;
  logic               to_hit;
  logic [BURST_W:0]   sent_p1;
  logic [BURST_W:0]   acked_p1;
  logic [BURST_W:0]   len_x;

  assign len_x    = {1'b0, len_i};
  assign sent_p1  = {1'b0, sent_q} + 1'b1;
  assign acked_p1 = {1'b0, acked_q} + 1'b1;

  assign active = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign CYC_O  = active || (state_q == S_REQ);
  assign STB_O  = (state_q == S_ISSUE)
               && (sent_q < len_i)
               && (outst_q < OUT_W'(MAX_OUT));

  assign accept   = STB_O && !STALL_I;
  assign last_acc = accept && (sent_p1 == len_x);
  assign last_ack = ACK_I && (acked_p1 == len_x);

  assign abort_err = CYC_O && (ERR_I || to_hit);
  assign abort_rty = CYC_O && RTY_I && !abort_err;

  assign next_o  = accept && (sent_p1 < len_x)
                && !abort_err && !abort_rty;
  assign done_o  = (state_q == S_DONE);
  assign retry_o = (state_q == S_RTY);
  assign error_o = (state_q == S_ERR);

  assign WE_O       = we_i;
  assign ADR_O      = adr_i;
  assign DAT_O      = dat_i;
  assign SEL_O      = sel_i;
  assign rd_data_o  = DAT_I;
  assign rd_valid_o = ACK_I && CYC_O && !WE_O;

  // Cycle type: classic for single beats, end-of-burst on the last beat.
  always_comb begin
    CTI_O = 3'b000;
    if ((state_q == S_ISSUE) && (len_i > BURST_W'(1))) begin
      CTI_O = (sent_p1 == len_x) ? 3'b111 : 3'b010;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;

  // Watchdog counts cycles with strobes in flight and no ACK.
  always_comb begin
    wdog_d = '0;
    if (active && !ACK_I && ((outst_q != '0) || accept)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign to_hit = active && (wdog_d == WD_W'(TIMEOUT_CYC));

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  // No watchdog in this build: only the slave can end a stuck cycle.
  assign to_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  // Burst sequencing and beat/ACK bookkeeping.
  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    acked_d = acked_q;
    outst_d = outst_q;
    if (active) begin
      if (accept) sent_d = sent_q + 1'b1;
      if (ACK_I) acked_d = acked_q + 1'b1;
      unique case ({accept, ACK_I})
        2'b10:   outst_d = outst_q + 1'b1;
        2'b01:   outst_d = outst_q - 1'b1;
        default: outst_d = outst_q;
      endcase
    end
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = (len_i == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (abort_err)      state_d = S_ERR;
        else if (abort_rty) state_d = S_RTY;
        else if (gnt_i)     state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort_err)      state_d = S_ERR;
        else if (abort_rty) state_d = S_RTY;
        else if (last_acc) begin
          state_d = last_ack ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_err)      state_d = S_ERR;
        else if (abort_rty) state_d = S_RTY;
        else if (last_ack)  state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        sent_d  = '0;
        acked_d = '0;
        outst_d = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sent_q  <= '0;
      acked_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      acked_q <= acked_d;
      outst_q <= outst_d;
    end
  end

endmodule

// File: tb/tb_wb_pipe_master.sv
// Directed bench for wb_pipe_master with a latency-programmable slave.
// Timeout case runs only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_pipe_master;

  localparam int BW = 7;
  localparam int MO = 4;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i, we_i, gnt_i;
  logic [31:0] adr_i, dat_i;
  logic [3:0]  sel_i;
  logic [BW-1:0] len_i;
  logic        next_o, done_o, retry_o, error_o, rd_valid_o;
  logic [31:0] rd_data_o;
  logic [31:0] DAT_I;
  logic        ACK_I, RTY_I, ERR_I, STALL_I;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [2:0]  CTI_O;

  always #5 clk = ~clk;

  wb_pipe_master #(
    .ADDR_W(32), .DATA_W(32), .BURST_W(BW),
    .MAX_OUT(MO), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .adr_i(adr_i), .dat_i(dat_i),
    .sel_i(sel_i), .we_i(we_i), .len_i(len_i),
    .next_o(next_o), .done_o(done_o),
    .retry_o(retry_o), .error_o(error_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .gnt_i(gnt_i), .DAT_I(DAT_I), .ACK_I(ACK_I),
    .RTY_I(RTY_I), .ERR_I(ERR_I), .STALL_I(STALL_I),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .CTI_O(CTI_O)
  );

  int checks = 0;
  int errors = 0;

  int n_acc, n_stb, n_next, n_next_stall, n_done;
  int n_rty, n_err, n_rdv, rd_bad, adr_bad, cti_bad;
  int full_seen, stb_full, cyc_cnt;
  int first_acc, last_ack_c, pulse_c, rty_c;
  logic       pulse_cyc_o;
  logic [9:0] rst_outs;
  logic [2:0] cti_last;
  int fin;
  int ackq[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic present(input int i);
    adr_i = 32'h1000_0000 + 32'(i) * 4;
    dat_i = 32'hA500_0000 + 32'(i);
    sel_i = 4'hF;
  endtask

  task automatic run_msg(input int len, input logic we,
                         input int lat, input int st_lo,
                         input int st_hi, input int rty_k,
                         input int err_k, input int rst_at);
    int cyc, nack, idx;
    logic acc, ackd, nxt, full;
    logic [2:0] ecti;
    cyc = 0; nack = 0; idx = 0; nxt = 1'b0; fin = 0;
    n_acc = 0; n_stb = 0; n_next = 0; n_next_stall = 0;
    n_done = 0; n_rty = 0; n_err = 0; n_rdv = 0;
    rd_bad = 0; adr_bad = 0; cti_bad = 0;
    full_seen = 0; stb_full = 0; cyc_cnt = 0;
    first_acc = -1; last_ack_c = -1; pulse_c = -1; rty_c = -1;
    pulse_cyc_o = 1'b1; rst_outs = '0; cti_last = '0;
    ackq.delete();
    @(negedge clk);
    req_i = 1'b1; len_i = BW'(len); we_i = we;
    present(0);
    while (fin == 0 && cyc < 300) begin
      if (cyc == rst_at) begin
        rst = 1'b1;
        req_i = 1'b0;
      end
      STALL_I = (cyc >= st_lo) && (cyc <= st_hi);
      #1;
      full = ((n_acc - nack) == MO);
      acc  = STB_O && !STALL_I;
      ackd = (lat == 0) ? acc
           : (ackq.size() > 0 && ackq[0] == cyc);
      if (ackd) begin
        DAT_I = 32'hD000_0000 + 32'(nack);
        if (nack + 1 == rty_k) RTY_I = 1'b1;
        else begin
          ACK_I = 1'b1;
          if (nack + 1 == err_k) ERR_I = 1'b1;
        end
      end
      #1;
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        rst_outs = {CYC_O, STB_O, next_o, done_o, retry_o,
                    error_o, rd_valid_o, CTI_O};
        rst = 1'b0;
        fin = 1;
      end else begin
        if (acc) begin
          if (ADR_O !== 32'h1000_0000 + 32'(n_acc) * 4) adr_bad++;
          if (len == 1) ecti = 3'b000;
          else if (n_acc == len - 1) ecti = 3'b111;
          else ecti = 3'b010;
          if (CTI_O !== ecti) cti_bad++;
          if (n_acc == len - 1) cti_last = CTI_O;
          if (first_acc < 0) first_acc = cyc;
          if (lat > 0) ackq.push_back(cyc + lat);
        end
        if (CYC_O && full && n_acc < len) begin
          full_seen++;
          if (STB_O) stb_full++;
        end
        if (rd_valid_o) begin
          n_rdv++;
          if (rd_data_o !== 32'hD000_0000 + 32'(nack)) rd_bad++;
        end
        if (acc) n_acc++;
        if (ackd) begin
          if (lat > 0) void'(ackq.pop_front());
          if (RTY_I) rty_c = cyc;
          nack++;
          last_ack_c = cyc;
        end
        if (next_o) begin
          n_next++;
          if (STALL_I) n_next_stall++;
          nxt = 1'b1;
        end
        n_stb   += int'(STB_O);
        cyc_cnt += int'(CYC_O);
        n_done  += int'(done_o);
        n_rty   += int'(retry_o);
        n_err   += int'(error_o);
        if (done_o || retry_o || error_o) begin
          fin = 1;
          pulse_c = cyc;
          pulse_cyc_o = CYC_O;
        end
      end
      @(negedge clk);
      cyc++;
      ACK_I = 1'b0; RTY_I = 1'b0; ERR_I = 1'b0;
      DAT_I = '0;
      if (nxt) begin
        idx++;
        present(idx);
        nxt = 1'b0;
      end
    end
    chk("bound", 32'(fin), 32'd1);
    req_i = 1'b0;
    STALL_I = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    req_i = 1'b0; we_i = 1'b0; gnt_i = 1'b1;
    len_i = '0; adr_i = '0; dat_i = '0; sel_i = '0;
    DAT_I = '0; ACK_I = 1'b0; RTY_I = 1'b0;
    ERR_I = 1'b0; STALL_I = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_state",
        {22'd0, CYC_O, STB_O, next_o, done_o, retry_o,
         error_o, rd_valid_o, CTI_O}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single write, zero-wait slave
    run_msg(1, 1'b1, 0, -1, -1, 0, 0, -1);
    chk("t1_acc", 32'(n_acc), 32'd1);
    chk("t1_stb", 32'(n_stb), 32'd1);
    chk("t1_next", 32'(n_next), 32'd0);
    chk("t1_cti", 32'(cti_last), 32'd0);
    chk("t1_done", 32'(n_done), 32'd1);
    chk("t1_done_lat", 32'(pulse_c - last_ack_c), 32'd1);
    chk("t1_cyc", 32'(cyc_cnt), 32'd2);
    chk("t1_rdv", 32'(n_rdv), 32'd0);

    // read burst of 8, ACK 4 cycles after accept
    run_msg(8, 1'b0, 4, -1, -1, 0, 0, -1);
    chk("t2_acc", 32'(n_acc), 32'd8);
    chk("t2_next", 32'(n_next), 32'd7);
    chk("t2_rdv", 32'(n_rdv), 32'd8);
    chk("t2_rdata", 32'(rd_bad), 32'd0);
    chk("t2_cti_last", 32'(cti_last), 32'd7);
    chk("t2_cti", 32'(cti_bad), 32'd0);
    chk("t2_done", 32'(n_done), 32'd1);
    chk("t2_full_seen", 32'(full_seen > 0), 32'd1);
    chk("t2_stb_full", 32'(stb_full), 32'd0);
    chk("t2_adr", 32'(adr_bad), 32'd0);
    chk("t2_done_lat", 32'(pulse_c - last_ack_c), 32'd1);

    // write of 4 with two stalled issue cycles
    run_msg(4, 1'b1, 1, 3, 4, 0, 0, -1);
    chk("t3_acc", 32'(n_acc), 32'd4);
    chk("t3_next", 32'(n_next), 32'd3);
    chk("t3_next_stall", 32'(n_next_stall), 32'd0);
    chk("t3_stb", 32'(n_stb), 32'd6);
    chk("t3_done", 32'(n_done), 32'd1);
    chk("t3_adr", 32'(adr_bad), 32'd0);

    // retry on second ACK, then clean reissue
    run_msg(4, 1'b1, 1, -1, -1, 2, 0, -1);
    chk("t4_rty", 32'(n_rty), 32'd1);
    chk("t4_done", 32'(n_done), 32'd0);
    chk("t4_rty_lat", 32'(pulse_c - rty_c), 32'd1);
    chk("t4_rty_cyc", 32'(pulse_cyc_o), 32'd0);
    run_msg(4, 1'b1, 1, -1, -1, 0, 0, -1);
    chk("t4r_done", 32'(n_done), 32'd1);
    chk("t4r_acc", 32'(n_acc), 32'd4);
    chk("t4r_adr", 32'(adr_bad), 32'd0);
    chk("t4r_rty", 32'(n_rty), 32'd0);

    // ERR together with ACK, then clean read
    run_msg(2, 1'b0, 1, -1, -1, 0, 1, -1);
    chk("t5_err", 32'(n_err), 32'd1);
    chk("t5_done", 32'(n_done), 32'd0);
    chk("t5_err_cyc", 32'(pulse_cyc_o), 32'd0);
    run_msg(2, 1'b0, 1, -1, -1, 0, 0, -1);
    chk("t5r_done", 32'(n_done), 32'd1);
    chk("t5r_acc", 32'(n_acc), 32'd2);
    chk("t5r_rdv", 32'(n_rdv), 32'd2);
    chk("t5r_rdata", 32'(rd_bad), 32'd0);

    // zero-length message
    run_msg(0, 1'b0, 1, -1, -1, 0, 0, -1);
    chk("t6_done", 32'(n_done), 32'd1);
    chk("t6_cyc", 32'(cyc_cnt), 32'd0);
    chk("t6_done_cyc", 32'(pulse_c), 32'd1);

    // reset in the middle of a burst
    run_msg(8, 1'b0, 4, -1, -1, 0, 0, 5);
    chk("t7_rst_outs", 32'(rst_outs), 32'd0);
    chk("t7_rty", 32'(n_rty), 32'd0);
    chk("t7_err", 32'(n_err), 32'd0);
    run_msg(2, 1'b1, 1, -1, -1, 0, 0, -1);
    chk("t7r_done", 32'(n_done), 32'd1);

`ifdef WB_MASTER_TIMEOUT_EN
    // silent slave: watchdog must fire
    run_msg(2, 1'b1, 1000, -1, -1, 0, 0, -1);
    chk("t8_err", 32'(n_err), 32'd1);
    chk("t8_done", 32'(n_done), 32'd0);
    chk("t8_err_lat", 32'(pulse_c - first_acc), 32'd16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
